// File: rtl/network_display_scanner.sv
// network_display_scanner
// Display front-end for the bitstream network. Picks one of N_OUT output
// channels (auto-scan on a refresh timer, or manual select), snapshots it,
// converts its magnitude to BCD serially (shift-and-add-3) and holds the
// digits plus sign/zero/overflow flags for the seven-segment drivers.
//
// Ports:
//   clk        system clock
//   n_rst      synchronous active-low reset
//   data_in    flattened channels, channel k at [k*DATA_W +: DATA_W]
//   auto_mode  1 = auto-scan on timer, 0 = manual select via sel
//   sel        manual channel select (out-of-range values are ignored)
//   digits     BCD digits, units digit at [3:0]
//   chan_idx   channel currently shown
//   neg        shown value is negative
//   nonzero    shown value is not zero
//   overflow   |value| exceeds DIGITS decimal digits; digits saturated to 9s
//   valid      one-cycle pulse when digits/flags update
//   busy       conversion in progress
module network_display_scanner #(
    parameter int N_OUT       = 4,
    parameter int DATA_W      = 16,
    parameter int DIGITS      = 3,
    parameter int SIGNED_IN   = 1,
    parameter int SCAN_CYCLES = 25000000,
    localparam int SEL_W      = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [N_OUT*DATA_W-1:0]   data_in,
    input  logic                      auto_mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [4*DIGITS-1:0]       digits,
    output logic [SEL_W-1:0]          chan_idx,
    output logic                      neg,
    output logic                      nonzero,
    output logic                      overflow,
    output logic                      valid,
    output logic                      busy
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam int TMR_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SCAN_CYCLES - 1);
    localparam logic [SEL_W:0]   N_OUT_W    = (SEL_W + 1)'(N_OUT);
    localparam logic [SEL_W-1:0] LAST_CHAN  = SEL_W'(N_OUT - 1);
    localparam logic [63:0]      MAX_DISP   = pow10(DIGITS) - 64'd1;

    // The refresh period must leave room for a whole conversion.
    generate
        if (SCAN_CYCLES < DATA_W + 4) begin : g_bad_scan
            $error("SCAN_CYCLES must be at least DATA_W+4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] chans [N_OUT];
    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_chan
        assign chans[gi] = data_in[gi*DATA_W +: DATA_W];
    end

    logic [TMR_W-1:0]  timer_reg;
    logic              pending_reg;
    logic              init_reg;
    logic [SEL_W-1:0]  sel_prev_reg;
    logic [SEL_W-1:0]  target_reg;
    logic [DATA_W-1:0] mag_reg;
    logic              neg_pend_reg;
    logic              ovf_pend_reg;
    logic              zero_pend_reg;
    logic [BCD_W-1:0]  bcd_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [BCD_W-1:0]  digits_reg;
    logic [SEL_W-1:0]  chan_idx_reg;
    logic              neg_reg;
    logic              nonzero_reg;
    logic              overflow_reg;

    logic              timer_hit;
    logic              sel_trig;
    logic              trig;
    logic              reload;
    logic [SEL_W-1:0]  next_chan;
    logic [SEL_W-1:0]  manual_target;
    logic [SEL_W-1:0]  target_choice;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] mag_load;
    logic              neg_load;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_shift;

    assign timer_hit = (timer_reg == '0);
    assign sel_trig  = !auto_mode && (sel != sel_prev_reg);
    // Any trigger starts a conversion from IDLE; the power-up trigger comes from init_reg.
    assign trig      = init_reg || timer_hit || sel_trig;
    // A sel change seen in DONE (or one latched earlier) chains straight into LOAD.
    assign reload    = pending_reg || sel_trig;

    always_comb begin
        next_chan     = (chan_idx_reg == LAST_CHAN) ? '0 : chan_idx_reg + 1'b1;
        manual_target = ({1'b0, sel} < N_OUT_W) ? sel : chan_idx_reg;
        if (init_reg)       target_choice = '0;
        else if (auto_mode) target_choice = next_chan;
        else                target_choice = manual_target;
    end

    always_comb begin
        raw      = chans[target_reg];
        mag_load = raw;
        neg_load = 1'b0;
        if (SIGNED_IN != 0 && raw[DATA_W-1]) begin
            // DATA_W-bit unsigned result, so the most-negative value stays exact.
            mag_load = (~raw) + 1'b1;
            neg_load = 1'b1;
        end
    end

    // One double-dabble step: adjust every nibble >= 5, then shift in the next magnitude bit.
    always_comb begin
        bcd_adj = bcd_reg;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_reg[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], mag_reg[DATA_W-1]};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trig) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (cnt_reg == CNT_W'(DATA_W - 1)) state_next = DONE;
            DONE:    state_next = reload ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // Track sel even in reset so a static sel never looks like a change.
        sel_prev_reg <= sel;
        if (!n_rst) begin
            state_reg     <= IDLE;
            timer_reg     <= TMR_RELOAD;
            pending_reg   <= 1'b0;
            init_reg      <= 1'b1;
            target_reg    <= '0;
            mag_reg       <= '0;
            neg_pend_reg  <= 1'b0;
            ovf_pend_reg  <= 1'b0;
            zero_pend_reg <= 1'b0;
            bcd_reg       <= '0;
            cnt_reg       <= '0;
            digits_reg    <= '0;
            chan_idx_reg  <= '0;
            neg_reg       <= 1'b0;
            nonzero_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_hit ? TMR_RELOAD : timer_reg - 1'b1;
            init_reg  <= 1'b0;

            if (state_reg == DONE)
                pending_reg <= 1'b0;
            else if (state_reg != IDLE && sel_trig)
                pending_reg <= 1'b1;

            case (state_reg)
                IDLE: if (trig) target_reg <= target_choice;
                LOAD: begin
                    mag_reg       <= mag_load;
                    neg_pend_reg  <= neg_load;
                    ovf_pend_reg  <= (64'(mag_load) > MAX_DISP);
                    zero_pend_reg <= (mag_load == '0);
                    bcd_reg       <= '0;
                    cnt_reg       <= '0;
                end
                SHIFT: begin
                    bcd_reg <= bcd_shift;
                    mag_reg <= {mag_reg[DATA_W-2:0], 1'b0};
                    cnt_reg <= cnt_reg + 1'b1;
                    // Results land on entry to DONE so they coincide with the valid pulse.
                    if (state_next == DONE) begin
                        digits_reg   <= ovf_pend_reg ? {DIGITS{4'h9}} : bcd_shift;
                        neg_reg      <= neg_pend_reg && !zero_pend_reg;
                        nonzero_reg  <= !zero_pend_reg;
                        overflow_reg <= ovf_pend_reg;
                        chan_idx_reg <= target_reg;
                    end
                end
                DONE: if (reload) target_reg <= target_choice;
                default: ;
            endcase
        end
    end

    assign digits   = digits_reg;
    assign chan_idx = chan_idx_reg;
    assign neg      = neg_reg;
    assign nonzero  = nonzero_reg;
    assign overflow = overflow_reg;
    assign valid    = (state_reg == DONE);
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_network_display_scanner.sv
module tb_network_display_scanner;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        n_rst;
    logic [63:0] data_in;
    logic        auto_mode;
    logic [1:0]  sel;
    logic [11:0] digits;
    logic [1:0]  chan_idx;
    logic        neg, nonzero, overflow, valid, busy;

    logic [47:0] data3;
    logic        auto3;
    logic [1:0]  sel3;
    logic [11:0] digits3;
    logic [1:0]  chan3;
    logic        neg3, nz3, ovf3, valid3, busy3;

    int checks   = 0;
    int failures = 0;

    network_display_scanner #(.N_OUT(4), .DATA_W(16), .DIGITS(3), .SIGNED_IN(1), .SCAN_CYCLES(32)) dut (
        .clk(clk), .n_rst(n_rst), .data_in(data_in), .auto_mode(auto_mode), .sel(sel),
        .digits(digits), .chan_idx(chan_idx), .neg(neg), .nonzero(nonzero),
        .overflow(overflow), .valid(valid), .busy(busy)
    );

    network_display_scanner #(.N_OUT(3), .DATA_W(16), .DIGITS(3), .SIGNED_IN(1), .SCAN_CYCLES(32)) dut3 (
        .clk(clk), .n_rst(n_rst), .data_in(data3), .auto_mode(auto3), .sel(sel3),
        .digits(digits3), .chan_idx(chan3), .neg(neg3), .nonzero(nz3),
        .overflow(ovf3), .valid(valid3), .busy(busy3)
    );

    // Cycles until valid is seen (sampled 1 time unit after each edge); -1 on timeout.
    task automatic wait_valid(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (valid) begin cyc = i; return; end
        end
    endtask

    task automatic wait_valid3(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (valid3) begin cyc = i; return; end
        end
    endtask

    task automatic check_result(input string name, input int cyc, input int exp_cyc,
                                input logic [11:0] exp_d, input logic [1:0] exp_ch,
                                input logic exp_neg, input logic exp_nz, input logic exp_ovf);
        checks++;
        if (cyc !== exp_cyc) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_cyc);
        end
        checks++;
        if ({digits, chan_idx, neg, nonzero, overflow} !== {exp_d, exp_ch, exp_neg, exp_nz, exp_ovf}) begin
            failures++;
            $display("FAIL %s result: got digits=%h ch=%0d neg=%b nz=%b ovf=%b expected digits=%h ch=%0d neg=%b nz=%b ovf=%b",
                     name, digits, chan_idx, neg, nonzero, overflow, exp_d, exp_ch, exp_neg, exp_nz, exp_ovf);
        end else begin
            $display("ok %s: digits=%h ch=%0d neg=%b nz=%b ovf=%b after %0d cycles",
                     name, digits, chan_idx, neg, nonzero, overflow, cyc);
        end
    endtask

    task automatic test_reset();
        int cyc;
        n_rst = 1'b0; auto_mode = 1'b0; sel = 2'd0; data_in = '0;
        data_in[15:0] = 16'd124;
        auto3 = 1'b0; sel3 = 2'd0;
        data3 = {16'd7, 16'd6, 16'd5};
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({digits, chan_idx, neg, nonzero, overflow, valid, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got digits=%h ch=%0d flags=%b%b%b%b%b expected all 0",
                     digits, chan_idx, neg, nonzero, overflow, valid, busy);
        end else $display("ok reset_outputs: all zero");
        n_rst = 1'b1;
        wait_valid(cyc);
        check_result("initial_ch0", cyc, 18, 12'h124, 2'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_auto_scan();
        logic [11:0] exp_d  [4] = '{12'h082, 12'h000, 12'h007, 12'h124};
        logic [1:0]  exp_ch [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic        exp_ng [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic        exp_nz [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        int          exp_gap[4] = '{31, 32, 32, 32};
        int cyc;
        data_in[31:16] = 16'd82;
        data_in[47:32] = 16'd0;
        data_in[63:48] = 16'hFFF9;
        auto_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(cyc);
            check_result($sformatf("auto_step%0d", k), cyc, exp_gap[k], exp_d[k], exp_ch[k],
                         exp_ng[k], exp_nz[k], 1'b0);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        auto_mode = 1'b0;
        data_in[31:16] = 16'd1000;
        data_in[47:32] = 16'h8000;
        @(posedge clk); #1;
        sel = 2'd1;
        wait_valid(cyc);
        check_result("ovf_ch1_1000", cyc, 18, 12'h999, 2'd1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        sel = 2'd2;
        wait_valid(cyc);
        check_result("ovf_ch2_most_neg", cyc, 18, 12'h999, 2'd2, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        int cyc;
        data_in[47:32] = 16'd82;
        @(posedge clk); #1;
        sel = 2'd0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({busy, valid} !== 2'b10) begin
            failures++;
            $display("FAIL b2b_busy_mid: got busy=%b valid=%b expected busy=1 valid=0", busy, valid);
        end else $display("ok b2b_busy_mid: busy=1");
        sel = 2'd2;
        wait_valid(cyc);
        check_result("b2b_first_ch0", cyc, 13, 12'h124, 2'd0, 1'b0, 1'b1, 1'b0);
        wait_valid(cyc);
        check_result("b2b_pending_ch2", cyc, 18, 12'h082, 2'd2, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_extra: got busy=%b expected 0", busy);
        end else $display("ok b2b_no_extra: idle after pending conversion");
    endtask

    task automatic test_reset_mid();
        int cyc;
        int seen;
        @(posedge clk); #1;
        sel = 2'd0;
        seen = 0;
        repeat (7) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        checks++;
        if ({busy, seen} !== {1'b1, 32'd0}) begin
            failures++;
            $display("FAIL rst_mid_before: got busy=%b valids=%0d expected busy=1 valids=0", busy, seen);
        end else $display("ok rst_mid_before: converting at shift cycle 5");
        n_rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({digits, chan_idx, neg, nonzero, overflow, valid, busy} !== '0) begin
            failures++;
            $display("FAIL rst_mid_outputs: got digits=%h ch=%0d flags=%b%b%b%b%b expected all 0",
                     digits, chan_idx, neg, nonzero, overflow, valid, busy);
        end else $display("ok rst_mid_outputs: all zero, no valid");
        n_rst = 1'b1;
        wait_valid(cyc);
        check_result("rst_mid_restart", cyc, 18, 12'h124, 2'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_sel_range();
        int cyc;
        wait_valid3(cyc);
        @(posedge clk); #1;
        sel3 = 2'd2;
        wait_valid3(cyc);
        checks++;
        if ({cyc, digits3, chan3, neg3, nz3, ovf3} !== {32'd18, 12'h007, 2'd2, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL n3_sel2: got cyc=%0d digits=%h ch=%0d neg=%b nz=%b ovf=%b expected 18 007 2 0 1 0",
                     cyc, digits3, chan3, neg3, nz3, ovf3);
        end else $display("ok n3_sel2: digits=%h ch=%0d", digits3, chan3);
        data3[47:32] = 16'd9;
        @(posedge clk); #1;
        sel3 = 2'd3;
        wait_valid3(cyc);
        checks++;
        if ({cyc, digits3, chan3, neg3, nz3, ovf3} !== {32'd18, 12'h009, 2'd2, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL n3_sel_out_of_range: got cyc=%0d digits=%h ch=%0d neg=%b nz=%b ovf=%b expected 18 009 2 0 1 0",
                     cyc, digits3, chan3, neg3, nz3, ovf3);
        end else $display("ok n3_sel_out_of_range: digits=%h ch=%0d", digits3, chan3);
    endtask

    initial begin
        test_reset();
        test_auto_scan();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_sel_range();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
